// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM input pin, the capture block and the control logic that reads results.
`timescale 1ns/1ps
interface pwm_capture_if #(
  parameter int CNT_W = 24
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             level_stuck;
  logic             stuck_level;

  modport master (
    output pwm_in,
    input  high_time,
    input  period,
    input  meas_valid,
    input  level_stuck,
    input  stuck_level
  );

  modport slave (
    input  pwm_in,
    output high_time,
    output period,
    output meas_valid,
    output level_stuck,
    output stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM line in clk cycles and flags a line
// that has stopped toggling for TIMEOUT cycles.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int          CNT_W   = 24,
  parameter int unsigned TIMEOUT = 10_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] L_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] L_TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_period;
  logic             r_meas_valid;
  logic             r_level_stuck;
  logic             r_stuck_level;

  logic w_rise;
  logic w_fall;
  logic w_timeout;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  // A rise on the last allowed count completes a valid period, so it beats the timeout.
  assign w_timeout = (r_pcnt == L_TO_LAST) && !w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_SYNC;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_hcnt        <= '0;
      r_pcnt        <= '0;
      r_high_time   <= '0;
      r_period      <= '0;
      r_meas_valid  <= 1'b0;
      r_level_stuck <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_s1         <= bus.pwm_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_meas_valid <= 1'b0;

      if (w_timeout) begin
        r_level_stuck <= 1'b1;
        r_stuck_level <= r_s2;
        r_hcnt        <= '0;
        r_pcnt        <= '0;
        r_state       <= S_SYNC;
      end else begin
        case (r_state)
          S_SYNC: begin
            // First edge after reset or timeout only aligns us; the partial period is dropped.
            if (w_rise) begin
              r_hcnt  <= L_ONE;
              r_pcnt  <= L_ONE;
              r_state <= S_HIGH;
            end else begin
              r_pcnt <= r_pcnt + L_ONE;
            end
          end
          S_HIGH: begin
            r_pcnt <= r_pcnt + L_ONE;
            if (w_fall) begin
              r_state <= S_LOW;
            end else begin
              r_hcnt <= r_hcnt + L_ONE;
            end
          end
          S_LOW: begin
            if (w_rise) begin
              r_high_time   <= r_hcnt;
              r_period      <= r_pcnt;
              r_meas_valid  <= 1'b1;
              r_level_stuck <= 1'b0;
              r_hcnt        <= L_ONE;
              r_pcnt        <= L_ONE;
              r_state       <= S_HIGH;
            end else begin
              r_pcnt <= r_pcnt + L_ONE;
            end
          end
          default: begin
            r_hcnt  <= '0;
            r_pcnt  <= '0;
            r_state <= S_SYNC;
          end
        endcase
      end
    end
  end

  assign bus.high_time   = r_high_time;
  assign bus.period      = r_period;
  assign bus.meas_valid  = r_meas_valid;
  assign bus.level_stuck = r_level_stuck;
  assign bus.stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven PWM segments, a result scoreboard and
// hand-written timeout / reset sequences.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 1000;

  typedef struct {
    int h;
    int l;
    int reps;
    int exp_h;
    int exp_p;
    bit exp_valid;
  } seg_t;

  typedef struct {
    int h;
    int p;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  bit   pend_valid = 1'b0;
  int   pend_h = 0;
  int   pend_p = 0;
  logic prev_level = 1'b0;
  logic mv_prev = 1'b0;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One input cycle: sample DUT outputs at the falling edge, then drive the next line level.
  task automatic tick(input logic level);
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missed_meas: no meas_valid at cycle %0d, required high_time=%0d period=%0d", e.due, e.h, e.p);
    end
    if (bus.meas_valid) begin
      chk("meas_valid_gap", int'(mv_prev), 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_meas: got high_time=%0d period=%0d at cycle %0d, required no pulse",
                 bus.high_time, bus.period, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("high_time", int'(bus.high_time), e.h);
        chk("period", int'(bus.period), e.p);
        chk("meas_cycle", cyc, e.due);
        chk("stuck_clear_on_meas", int'(bus.level_stuck), 0);
      end
    end
    mv_prev = bus.meas_valid;
    bus.pwm_in = level;
    if (level && !prev_level && pend_valid) begin
      e.h   = pend_h;
      e.p   = pend_p;
      e.due = cyc + 3;
      exp_q.push_back(e);
    end
    prev_level = level;
  endtask

  task automatic drive_seg(input seg_t s);
    for (int r = 0; r < s.reps; r++) begin
      tick(1'b1);
      pend_valid = s.exp_valid;
      pend_h     = s.exp_h;
      pend_p     = s.exp_p;
      for (int i = 1; i < s.h; i++) tick(1'b1);
      for (int i = 0; i < s.l; i++) tick(1'b0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    seg_t tbl[6];
    seg_t resume;
    int   n;

    tbl[0] = '{h: 30, l: 70,  reps: 3, exp_h: 30, exp_p: 100, exp_valid: 1'b1};
    tbl[1] = '{h: 60, l: 40,  reps: 3, exp_h: 60, exp_p: 100, exp_valid: 1'b1};
    tbl[2] = '{h: 1,  l: 998, reps: 2, exp_h: 1,  exp_p: 999, exp_valid: 1'b1};
    tbl[3] = '{h: 1,  l: 999, reps: 1, exp_h: 0,  exp_p: 0,   exp_valid: 1'b0};
    tbl[4] = '{h: 30, l: 70,  reps: 2, exp_h: 30, exp_p: 100, exp_valid: 1'b1};
    tbl[5] = '{h: 30, l: 70,  reps: 2, exp_h: 30, exp_p: 100, exp_valid: 1'b1};
    resume = '{h: 30, l: 70,  reps: 1, exp_h: 30, exp_p: 100, exp_valid: 1'b1};

    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);
    chk("rst_high_time", int'(bus.high_time), 0);
    chk("rst_period", int'(bus.period), 0);
    chk("rst_meas_valid", int'(bus.meas_valid), 0);
    chk("rst_level_stuck", int'(bus.level_stuck), 0);
    chk("rst_stuck_level", int'(bus.stuck_level), 0);
    rst_n = 1'b1;
    tick(1'b0);

    // Steady 30/70, duty step to 60/40, 999-cycle boundary, 1000-cycle timeout, back to 30/70.
    for (int s = 0; s < 5; s++) drive_seg(tbl[s]);

    // Stuck low after one more high phase: timeout lands 1000 cycles after the rise cycle.
    tick(1'b1);
    n = cyc;
    pend_valid = 1'b0;
    for (int i = 1; i < 30; i++) tick(1'b1);
    while (cyc < n + 1001) tick(1'b0);
    chk("stuck_low_early", int'(bus.level_stuck), 0);
    tick(1'b0);
    chk("stuck_low_flag", int'(bus.level_stuck), 1);
    chk("stuck_low_level", int'(bus.stuck_level), 0);
    chk("stuck_low_hold_high", int'(bus.high_time), 30);
    chk("stuck_low_hold_period", int'(bus.period), 100);
    for (int i = 0; i < 20; i++) tick(1'b0);

    // First rise after timeout only resynchronises; flag stays set until a real measurement.
    drive_seg(resume);
    chk("stuck_after_sync_rise", int'(bus.level_stuck), 1);
    drive_seg(tbl[5]);
    chk("stuck_cleared", int'(bus.level_stuck), 0);

    // Stuck high: fires at 1000, refires every 1000, then refreshes the level after the line drops.
    tick(1'b1);
    n = cyc;
    pend_valid = 1'b0;
    while (cyc < n + 1001) tick(1'b1);
    chk("stuck_high_early", int'(bus.level_stuck), 0);
    tick(1'b1);
    chk("stuck_high_flag", int'(bus.level_stuck), 1);
    chk("stuck_high_level", int'(bus.stuck_level), 1);
    chk("stuck_high_hold_high", int'(bus.high_time), 30);
    chk("stuck_high_hold_period", int'(bus.period), 100);
    while (cyc < n + 2003) tick(1'b1);
    chk("stuck_high_refire", int'(bus.level_stuck), 1);
    while (cyc < n + 3001) tick(1'b0);
    chk("refresh_before", int'(bus.stuck_level), 1);
    tick(1'b0);
    chk("refresh_level", int'(bus.stuck_level), 0);
    chk("refresh_flag", int'(bus.level_stuck), 1);

    // Reset during a high phase: outputs clear at once, next result needs two rises.
    drive_seg(tbl[4]);
    for (int i = 0; i < 10; i++) tick(1'b1);
    chk("pre_reset_period", int'(bus.period), 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_high_time", int'(bus.high_time), 0);
    chk("midrst_period", int'(bus.period), 0);
    chk("midrst_meas_valid", int'(bus.meas_valid), 0);
    chk("midrst_level_stuck", int'(bus.level_stuck), 0);
    chk("midrst_stuck_level", int'(bus.stuck_level), 0);
    pend_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0);
    drive_seg(tbl[0]);
    tick(1'b1);
    pend_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1);
    chk("post_reset_period", int'(bus.period), 100);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
